// File: rtl/interrupt_ctrl_pkg.sv
// Shared types, vectors and FSM encodings for the interrupt/reset arbiter.
// Optional pin synchronisers are enabled with the INT_SYNC_EN macro.
package interrupt_ctrl_pkg;

  typedef enum logic [2:0] {
    IntNone  = 3'd0,
    IntReset = 3'd1,
    IntNMI   = 3'd2,
    IntIRQ   = 3'd3,
    IntBRK   = 3'd4
  } IntType;

  localparam logic [15:0] VEC_NMI   = 16'hFFFA;
  localparam logic [15:0] VEC_RESET = 16'hFFFC;
  localparam logic [15:0] VEC_IRQ   = 16'hFFFE;

  localparam logic [1:0] ST_RST_SEQ = 2'd0;
  localparam logic [1:0] ST_IDLE    = 2'd1;
  localparam logic [1:0] ST_PENDING = 2'd2;
  localparam logic [1:0] ST_SERVICE = 2'd3;

  // IRQ, BRK and the idle default all share the FFFE vector.
  function automatic logic [15:0] vec_of(input IntType t);
    case (t)
      IntNMI:   vec_of = VEC_NMI;
      IntReset: vec_of = VEC_RESET;
      default:  vec_of = VEC_IRQ;
    endcase
  endfunction

endpackage

// File: rtl/interrupt_ctrl_sync.sv
// Pin conditioner: optional two-flop synchroniser (INT_SYNC_EN) plus a
// falling-edge detector on the conditioned level.
module int_sync (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic level,
  output logic fall
);

  logic level_d;

`ifdef INT_SYNC_EN
  logic meta;
  logic sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b1;
      sync <= 1'b1;
    end else begin
      meta <= pin;
      sync <= meta;
    end
  end

  assign level = sync;
`else
  assign level = pin;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) level_d <= 1'b1;
    else     level_d <= level;
  end

  // High for one cycle after level goes 1->0; consumed by a registered latch.
  assign fall = level_d & ~level;

endmodule

// File: rtl/interrupt_ctrl.sv
// Interrupt/reset arbiter feeding the CPU sequencer via req/ack/done.
// Build option INT_SYNC_EN adds two-flop synchronisers on n_nmi and n_irq.
// Handshake: int_req is a level held from poll (or reset) until ack is
// sampled; the sequencer then runs the sequence and pulses done once the PC
// holds the vector. ack outside RstSeq/Pending and done outside Service are
// ignored.
import interrupt_ctrl_pkg::*;

module interrupt_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        n_nmi,
  input  logic        n_irq,
  input  logic        p_i,
  input  logic        brk,
  input  logic        poll,
  input  logic        ack,
  input  logic        done,
  output logic        int_req,
  output IntType      int_type,
  output logic [15:0] vec_addr,
  output logic        b_flag,
  output logic        no_write,
  output logic        set_i,
  output logic [1:0]  state,
  output logic        nmi_pend
);

  IntType cur_type;
  logic   nmi_s;
  logic   nmi_fall;
  logic   irq_s;
  logic   irq_act;
  logic   take_ack;

  int_sync u_nmi_sync (
    .clk   (clk),
    .rst   (reset),
    .pin   (n_nmi),
    .level (nmi_s),
    .fall  (nmi_fall)
  );

  int_sync u_irq_sync (
    .clk   (clk),
    .rst   (reset),
    .pin   (n_irq),
    .level (irq_s),
    .fall  ()
  );

  assign irq_act  = ~irq_s & ~p_i;
  assign take_ack = ack & (state == ST_PENDING);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_RST_SEQ;
      cur_type <= IntReset;
      b_flag   <= 1'b0;
      set_i    <= 1'b0;
      nmi_pend <= 1'b0;
    end else begin
      set_i <= 1'b0;

      // A new edge in the ack cycle must survive, so set beats clear.
      if (nmi_fall)
        nmi_pend <= 1'b1;
      else if (take_ack && cur_type == IntNMI)
        nmi_pend <= 1'b0;

      case (state)
        ST_RST_SEQ: begin
          if (ack) begin
            state <= ST_SERVICE;
            set_i <= 1'b1;
          end
        end
        ST_IDLE: begin
          if (poll) begin
            if (nmi_pend) begin
              cur_type <= IntNMI;
              b_flag   <= brk;
              state    <= ST_PENDING;
            end else if (brk) begin
              cur_type <= IntBRK;
              b_flag   <= 1'b1;
              state    <= ST_PENDING;
            end else if (irq_act) begin
              cur_type <= IntIRQ;
              b_flag   <= 1'b0;
              state    <= ST_PENDING;
            end
          end
        end
        ST_PENDING: begin
          if (ack) begin
            state <= ST_SERVICE;
            set_i <= 1'b1;
          end
        end
        default: begin
          if (done) begin
            state  <= ST_IDLE;
            b_flag <= 1'b0;
          end
        end
      endcase
    end
  end

  assign int_req  = (state == ST_RST_SEQ) || (state == ST_PENDING);
  assign int_type = (state == ST_IDLE) ? IntNone : cur_type;
  assign vec_addr = vec_of(int_type);
  assign no_write = (state == ST_RST_SEQ) ||
                    ((state == ST_SERVICE) && (cur_type == IntReset));

endmodule

// File: tb/tb_interrupt_ctrl.sv
// Directed bench for interrupt_ctrl in the default (unsynchronised) build.
import interrupt_ctrl_pkg::*;

module tb_interrupt_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        n_nmi, n_irq, p_i, brk, poll, ack, done;
  logic        int_req;
  IntType      int_type;
  logic [15:0] vec_addr;
  logic        b_flag, no_write, set_i;
  logic [1:0]  state;
  logic        nmi_pend;

  int vectors = 0;
  int miscompares = 0;

  interrupt_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .n_nmi    (n_nmi),
    .n_irq    (n_irq),
    .p_i      (p_i),
    .brk      (brk),
    .poll     (poll),
    .ack      (ack),
    .done     (done),
    .int_req  (int_req),
    .int_type (int_type),
    .vec_addr (vec_addr),
    .b_flag   (b_flag),
    .no_write (no_write),
    .set_i    (set_i),
    .state    (state),
    .nmi_pend (nmi_pend)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  int     nmi_reqs;
  logic   prev_req;
  IntType rec_type;
  logic [15:0] rec_vec;
  logic   rec_b;

  initial begin
    reset = 1'b1; n_nmi = 1'b1; n_irq = 1'b1; p_i = 1'b1;
    brk = 1'b0; poll = 1'b0; ack = 1'b0; done = 1'b0;
    #2;
    check("rst_state",   state,    ST_RST_SEQ);
    check("rst_req",     int_req,  1'b1);
    check("rst_type",    int_type, IntReset);
    check("rst_vec",     vec_addr, 16'hFFFC);
    check("rst_nowrite", no_write, 1'b1);
    check("rst_bflag",   b_flag,   1'b0);
    check("rst_seti",    set_i,    1'b0);
    check("rst_nmipend", nmi_pend, 1'b0);

    // Reset sequence handshake
    tick(); reset = 1'b0;
    tick();
    check("rseq_hold_req", int_req, 1'b1);
    ack = 1'b1; tick(); ack = 1'b0;
    check("rseq_svc_state", state,    ST_SERVICE);
    check("rseq_seti",      set_i,    1'b1);
    check("rseq_req_low",   int_req,  1'b0);
    check("rseq_type",      int_type, IntReset);
    check("rseq_vec",       vec_addr, 16'hFFFC);
    check("rseq_nowrite",   no_write, 1'b1);
    tick();
    check("rseq_seti_once", set_i,    1'b0);
    check("rseq_nowrite2",  no_write, 1'b1);
    done = 1'b1; tick(); done = 1'b0;
    check("idle_state",   state,    ST_IDLE);
    check("idle_type",    int_type, IntNone);
    check("idle_vec",     vec_addr, 16'hFFFE);
    check("idle_nowrite", no_write, 1'b0);
    check("idle_req",     int_req,  1'b0);

    // Stray ack/done in Idle are ignored
    ack = 1'b1; done = 1'b1; tick(); ack = 1'b0; done = 1'b0;
    check("stray_state", state, ST_IDLE);
    check("stray_seti",  set_i, 1'b0);

    // Held-low NMI with a poll every 8 cycles gives exactly one request
    n_nmi = 1'b0; tick();
    check("nmi_latency", nmi_pend, 1'b1);
    nmi_reqs = 0; prev_req = 1'b0;
    rec_type = IntNone; rec_vec = 16'h0000; rec_b = 1'b1;
    for (int i = 0; i < 50; i++) begin
      poll = (i % 8 == 0) && (state == ST_IDLE);
      ack  = int_req;
      done = (state == ST_SERVICE);
      tick();
      poll = 1'b0; ack = 1'b0; done = 1'b0;
      if (int_req && !prev_req) begin
        nmi_reqs++;
        rec_type = int_type; rec_vec = vec_addr; rec_b = b_flag;
      end
      prev_req = int_req;
    end
    check("nmi_count",   nmi_reqs[15:0], 16'd1);
    check("nmi_type",    rec_type,       IntNMI);
    check("nmi_vec",     rec_vec,        16'hFFFA);
    check("nmi_bflag",   rec_b,          1'b0);
    check("nmi_cleared", nmi_pend,       1'b0);
    n_nmi = 1'b1; tick();

    // IRQ masked, then unmasked; release before ack still serviced
    n_irq = 1'b0; p_i = 1'b1; poll = 1'b1; tick(); poll = 1'b0;
    check("irq_masked_state", state,   ST_IDLE);
    check("irq_masked_req",   int_req, 1'b0);
    p_i = 1'b0; poll = 1'b1; tick(); poll = 1'b0;
    check("irq_state", state,    ST_PENDING);
    check("irq_req",   int_req,  1'b1);
    check("irq_type",  int_type, IntIRQ);
    check("irq_vec",   vec_addr, 16'hFFFE);
    check("irq_bflag", b_flag,   1'b0);
    n_irq = 1'b1; p_i = 1'b1; done = 1'b1; tick(); done = 1'b0;
    check("irq_keep_pending", state,    ST_PENDING);
    check("irq_keep_type",    int_type, IntIRQ);
    ack = 1'b1; tick(); ack = 1'b0;
    check("irq_svc",  state, ST_SERVICE);
    check("irq_seti", set_i, 1'b1);
    brk = 1'b1; poll = 1'b1; tick(); brk = 1'b0; poll = 1'b0;
    check("svc_poll_ignored", state,    ST_SERVICE);
    check("svc_poll_type",    int_type, IntIRQ);
    done = 1'b1; tick(); done = 1'b0;
    check("irq_done", state, ST_IDLE);

    // Plain BRK
    brk = 1'b1; poll = 1'b1; tick(); brk = 1'b0; poll = 1'b0;
    check("brk_type",  int_type, IntBRK);
    check("brk_vec",   vec_addr, 16'hFFFE);
    check("brk_bflag", b_flag,   1'b1);
    ack = 1'b1; tick(); ack = 1'b0;
    check("brk_svc_bflag", b_flag, 1'b1);
    done = 1'b1; tick(); done = 1'b0;
    check("brk_done_bflag", b_flag, 1'b0);

    // BRK hijacked by a pending NMI
    n_nmi = 1'b0; tick(); n_nmi = 1'b1;
    check("hij_pend", nmi_pend, 1'b1);
    brk = 1'b1; poll = 1'b1; tick(); brk = 1'b0; poll = 1'b0;
    check("hij_type",  int_type, IntNMI);
    check("hij_vec",   vec_addr, 16'hFFFA);
    check("hij_bflag", b_flag,   1'b1);
    check("hij_pend2", nmi_pend, 1'b1);
    ack = 1'b1; tick(); ack = 1'b0;
    check("hij_ack_clear", nmi_pend, 1'b0);
    check("hij_svc_bflag", b_flag,   1'b1);
    done = 1'b1; tick(); done = 1'b0;
    check("hij_done_bflag", b_flag, 1'b0);

    // Second NMI edge lands in the ack cycle of the first
    n_nmi = 1'b0; tick();
    poll = 1'b1; tick(); poll = 1'b0;
    check("nmi2_first_type", int_type, IntNMI);
    n_nmi = 1'b1; tick();
    n_nmi = 1'b0; ack = 1'b1; tick(); ack = 1'b0;
    check("nmi2_set_wins", nmi_pend, 1'b1);
    check("nmi2_svc",      state,    ST_SERVICE);
    done = 1'b1; tick(); done = 1'b0;
    poll = 1'b1; tick(); poll = 1'b0;
    check("nmi2_second_state", state,    ST_PENDING);
    check("nmi2_second_type",  int_type, IntNMI);
    check("nmi2_second_vec",   vec_addr, 16'hFFFA);
    check("nmi2_second_bflag", b_flag,   1'b0);
    ack = 1'b1; tick(); ack = 1'b0;
    check("nmi2_cleared", nmi_pend, 1'b0);
    done = 1'b1; tick(); done = 1'b0;
    n_nmi = 1'b1; tick();

    // Reset during Service discards a pending NMI
    n_irq = 1'b0; p_i = 1'b0; poll = 1'b1; tick(); poll = 1'b0;
    ack = 1'b1; tick(); ack = 1'b0;
    n_irq = 1'b1; p_i = 1'b1;
    n_nmi = 1'b0; tick(); n_nmi = 1'b1;
    check("mid_svc",  state,    ST_SERVICE);
    check("mid_pend", nmi_pend, 1'b1);
    reset = 1'b1; tick();
    check("mid_rst_state", state,    ST_RST_SEQ);
    check("mid_rst_type",  int_type, IntReset);
    check("mid_rst_vec",   vec_addr, 16'hFFFC);
    check("mid_rst_req",   int_req,  1'b1);
    check("mid_rst_pend",  nmi_pend, 1'b0);
    reset = 1'b0; tick();
    ack = 1'b1; tick(); ack = 1'b0;
    done = 1'b1; tick(); done = 1'b0;
    check("post_rst_idle", state, ST_IDLE);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/interrupt_ctrl.md
# interrupt_ctrl

Interrupt and reset arbiter sitting directly upstream of the CPU sequencer. It synchronises the external NMI and IRQ pins, latches NMI edges, and tracks the level-sensitive IRQ against the status I flag. At each instruction-boundary poll it arbitrates RESET/NMI/BRK/IRQ. It then hands the sequencer a request, an interrupt type and a vector address through a req/ack/done handshake.

## Interface
- No parameters.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `n_nmi`  in  1  external NMI pin, active-low, asynchronous.
- `n_irq`  in  1  external IRQ pin, active-low, asynchronous, level.
- `p_i`  in  1  status register I flag; 1 masks IRQ.
- `brk`  in  1  sequencer is executing BRK; sampled only with `poll`.
- `poll`  in  1  one-cycle pulse at the instruction boundary (Fetch).
- `ack`  in  1  sequencer has begun the interrupt sequence.
- `done`  in  1  sequencer has loaded the PC from the vector.
- `int_req`  out  1  request pending; level, held until `ack`.
- `int_type`  out  IntType  IntNone/IntReset/IntNMI/IntIRQ/IntBRK.
- `vec_addr`  out  16  vector low-byte address; high byte is at `vec_addr+1`.
- `b_flag`  out  1  B bit to push with P.
- `no_write`  out  1  suppress stack writes (reset sequence).
- `set_i`  out  1  one-cycle pulse that sets the I flag.

## Operation
- States: RstSeq, Idle, Pending, Service.
- On `reset`:
  - state=RstSeq.
  - nmi_pend=0; synchroniser flops=1.
  - `int_req`=1, `int_type`=IntReset, `vec_addr`=16'hFFFC.
  - `b_flag`=0, `no_write`=1, `set_i`=0.
- RstSeq: `int_req`=1 until `ack`, then go to Service with type IntReset.
- Idle: `int_req`=0, `int_type`=IntNone, `vec_addr`=16'hFFFE, `no_write`=0.
  - On `poll`, arbitrate by priority NMI(nmi_pend) > BRK > IRQ (irq_s low & ~`p_i`).
  - If a source wins, latch the type and go to Pending; otherwise stay in Idle.
  - If NMI and `brk` are both present: type=IntNMI and `b_flag`=1 (BRK hijack).
- Pending: `int_req`=1, and the latched type and vector are stable.
  - On `ack`, go to Service and clear nmi_pend if type=IntNMI.
  - IRQ deassertion or a `p_i` change after the poll does not cancel the request.
- Service: `int_req`=0, type and vector held.
  - `set_i`=1 in the first Service cycle only.
  - `no_write`=1 only for IntReset.
  - On `done`, go to Idle and clear `b_flag`.
- Vectors: NMI 16'hFFFA, Reset 16'hFFFC, IRQ/BRK 16'hFFFE.
- `b_flag`=1 for IntBRK and for hijacked NMI; 0 otherwise.
- NMI edge: registered falling edge of the synchronised nmi (nmi_s_d & ~nmi_s) sets nmi_pend. Set wins over clear in the same cycle.
- A held-low `n_nmi` gives exactly one request.
- `ack` outside RstSeq/Pending and `done` outside Service are ignored.
- `poll` outside Idle is ignored.
- `reset` mid-sequence aborts to RstSeq on the next edge and discards any pending NMI.

## Timing
- `n_nmi` fall to nmi_pend=1: 3 rising edges (2 sync, 1 edge latch) with `INT_SYNC_EN`; 1 edge without.
- `n_irq` to irq_s: 2 edges with `INT_SYNC_EN`; 0 edges (combinational) without.
- `poll` at edge N: `int_req`=1, `int_type` and `vec_addr` valid in cycle N+1.
- `ack` at edge M: Service from M+1; `set_i` high for cycle M+1 only.
- `int_req` may fall in the same cycle `ack` is sampled; the sequencer must not depend on it afterwards.
- All outputs are registered or decoded from registered state only. No combinational path from `poll`, `ack` or `done` to any output.

## Configuration
- `INT_SYNC_EN` defined: two-flop synchronisers (reset value 1) on `n_nmi` and `n_irq`.
- `INT_SYNC_EN` undefined: pins are used directly.
  - For synchronous test benches and single-clock FPGA builds only.
  - NMI latency drops to 1 edge; IRQ is seen in the poll cycle.

## Structure
- typepkg gains:
  - enum IntType {IntNone, IntReset, IntNMI, IntIRQ, IntBRK}.
  - localparams VEC_NMI=16'hFFFA, VEC_RESET=16'hFFFC, VEC_IRQ=16'hFFFE.
- Sub-module `int_sync`: 2-flop synchroniser plus registered falling-edge detector, instanced once per pin.
  - The edge output is unused for IRQ.
  - The `INT_SYNC_EN` bypass lives inside `int_sync`.

## Test plan
- Reset release, `ack`@2, `done`@5:
  - `int_type`=IntReset, `vec_addr`=FFFC, `no_write`=1 during cycles 3-5.
  - `set_i` pulse in cycle 3.
  - Idle in cycle 6.
- `n_nmi` falls and is held low 50 cycles, with `poll` every 8 cycles:
  - exactly one IntNMI with `vec_addr`=FFFA and `b_flag`=0.
  - With `INT_SYNC_EN`, nmi_pend rises 3 edges after the fall.
- `n_irq`=0 with `p_i`=1 at `poll`: no request.
  - Then `p_i`=0 at the next `poll`: IntIRQ, FFFE, `b_flag`=0.
  - Releasing `n_irq` before `ack` still completes service.
- `brk`=1 with `poll` and no NMI: IntBRK, FFFE, `b_flag`=1.
  - Repeat with nmi_pend=1: IntNMI, FFFA, `b_flag`=1, and nmi_pend is cleared on `ack`.
- Second NMI edge arriving in the `ack` cycle of the first NMI: nmi_pend stays 1 and a second IntNMI is served at the next `poll`.
- `reset` asserted while in Service: the next edge gives RstSeq, `int_type`=IntReset, nmi_pend=0.
